instr_fetch_unit: RTL

//  RV32I fetch stage directly upstream of the control unit: owns the PC, issues word requests to

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/ifu_fifo.sv | 38 +++
 rtl/instr_fetch_unit.sv | 82 ++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I types and constants for the fetch unit and control unit.
package rv32i_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {BOOT, RUN, HALT} ifu_state_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: redirect, instruction-memory and decode handshake signals of the fetch stage.
interface instr_fetch_unit_if;
  logic        i_pc_sel;
  logic [31:0] i_alu_data;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_instr_vld;
  logic        i_instr_rdy;
  logic        o_fault;
  modport master (
    input  i_pc_sel, i_alu_data, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
    output o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld, o_fault
  );
  modport slave (
    output i_pc_sel, i_alu_data, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_instr_rdy,
    input  o_imem_req, o_imem_addr, o_instr, o_pc, o_instr_vld, o_fault
  );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous in-order buffer of fetched instr/PC pairs with flush.
module ifu_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage - PC, imem requests, in-order buffer, redirect with stale-response drop.
// Define IFU_MISALIGN_TRAP_EN to halt with o_fault on a misaligned redirect target.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ifu_state_e state, state_n;
  logic [31:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, outstanding_n, drop, count;
  logic redirect, misalign, grant, rv, push, pop, empty, full;
  fetch_entry_t head;
  assign redirect = bus.i_pc_sel && state == RUN;
  assign target   = {bus.i_alu_data[31:2], 2'b00};
`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign = redirect && |bus.i_alu_data[1:0];
`else
  assign misalign = 1'b0;
`endif
  assign grant = bus.o_imem_req && bus.i_imem_gnt;
  assign rv    = bus.i_imem_rvalid && outstanding != '0;
  assign push  = rv && drop == '0 && !redirect;
  assign pop   = bus.o_instr_vld && bus.i_instr_rdy && !redirect;
  assign outstanding_n = outstanding + CW'(grant) - CW'(rv);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= BOOT;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == BOOT ? RUN : misalign ? HALT : state;
  end
  always_comb begin
    bus.o_imem_req  = state == RUN && !bus.i_pc_sel && !full && (outstanding + count) < CW'(FIFO_DEPTH);
    bus.o_imem_addr = fetch_pc;
    bus.o_instr_vld = state != HALT && !empty;
    bus.o_instr     = bus.o_instr_vld ? head.instr : '0;
    bus.o_pc        = bus.o_instr_vld ? head.pc : '0;
`ifdef IFU_MISALIGN_TRAP_EN
    bus.o_fault     = state == HALT;
`else
    bus.o_fault     = 1'b0;
`endif
  end
  // a redirect marks every still-pending request stale, including one answered this cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= outstanding_n;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (rv && drop != '0) drop <= drop - 1'b1;
      end
    end
  end
  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata   ('{instr: bus.i_imem_rdata, pc: resp_pc}),
    .rdata   (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );
endmodule
